// File: rtl/fetch_ctrl.sv
// Two-byte instruction fetch sequencer driving the ARF (PC) and IR strobes.
// Optional wait timeout enabled by defining FETCH_CTRL_TIMEOUT_EN.
module fetch_ctrl #(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic [1:0] arf_outasel,
  output logic [3:0] arf_rsel,
  output logic [1:0] arf_funsel,
  output logic       ir_enable,
  output logic [1:0] ir_funsel,
  output logic       ir_lh,
  output logic       busy,
  output logic       done,
  output logic       err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("fetch_ctrl: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_LO = 3'd1,
    REQ_HI = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef FETCH_CTRL_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_q, wait_d;
  logic       in_req;

  assign in_req = (state_q == REQ_LO) || (state_q == REQ_HI);

  // Counter is zero outside the REQ states, so entering REQ_LO/REQ_HI always starts from 0.
  always_comb begin
    wait_d = 8'd0;
    if (in_req && !mem_ready) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= 8'd0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign timeout = in_req && !mem_ready && (wait_q == WAIT_LAST);
  assign err     = (state_q == ERR);
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_rd      = 1'b0;
    arf_outasel = 2'b00;
    arf_rsel    = 4'b0000;
    arf_funsel  = 2'b00;
    ir_enable   = 1'b0;
    ir_funsel   = 2'b00;
    ir_lh       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      IDLE, ERR: begin
        if (start) begin
          state_d = REQ_LO;
        end
      end
      REQ_LO, REQ_HI: begin
        mem_rd      = 1'b1;
        arf_outasel = 2'b11;
        busy        = 1'b1;
        ir_lh       = (state_q == REQ_HI);
        // A byte arriving loads IR and bumps PC in the same cycle.
        if (mem_ready) begin
          ir_enable  = 1'b1;
          ir_funsel  = 2'b01;
          arf_rsel   = 4'b0001;
          arf_funsel = 2'b11;
          state_d    = (state_q == REQ_LO) ? REQ_HI : DONE;
        end else if (timeout) begin
          state_d = ERR;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random stimulus against a fetch-level model.
module tb_fetch_ctrl;
  localparam int TO = 8;
`ifdef FETCH_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, mem_ready;
  logic       mem_rd, ir_enable, ir_lh, busy, done, err;
  logic [1:0] arf_outasel, arf_funsel, ir_funsel;
  logic [3:0] arf_rsel;

  fetch_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .arf_outasel(arf_outasel), .arf_rsel(arf_rsel),
    .arf_funsel(arf_funsel), .ir_enable(ir_enable), .ir_funsel(ir_funsel),
    .ir_lh(ir_lh), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bench-side PC: counts increment strobes seen at the clock edge.
  int incs = 0;
  always @(posedge clk) begin
    if (arf_rsel[0] && arf_funsel == 2'b11) incs <= incs + 1;
  end
  logic [7:0] pc_base = 8'h00;
  function automatic logic [7:0] pc_now();
    return pc_base + 8'(incs);
  endfunction
  task automatic set_pc(input logic [7:0] v);
    pc_base = v - 8'(incs);
  endtask

  logic [15:0] act;
  assign act = {mem_rd, arf_outasel, arf_rsel, arf_funsel, ir_enable,
                ir_funsel, ir_lh, busy, done, err};

  // Fetch-level model: whether a fetch is in flight, bytes received so far,
  // consecutive wait cycles, the completion cycle and the sticky error.
  bit m_fetch = 0, m_done = 0, m_err = 0;
  int m_bytes = 0, m_wait = 0;

  function automatic logic [15:0] model_out();
    logic       mr, ie, lh, b, d, e;
    logic [1:0] oa, af, irf;
    logic [3:0] rs;
    mr = 0; ie = 0; lh = 0; b = 0; d = 0; e = 0;
    oa = 0; af = 0; irf = 0; rs = 0;
    if (m_done) begin
      b = 1; d = 1;
    end else if (m_fetch) begin
      mr = 1; oa = 2'b11; b = 1; lh = (m_bytes == 1);
      if (mem_ready) begin
        ie = 1; irf = 2'b01; rs = 4'b0001; af = 2'b11;
      end
    end else if (m_err) begin
      e = 1;
    end
    return {mr, oa, rs, af, ie, irf, lh, b, d, e};
  endfunction

  task automatic model_step();
    if (rst) begin
      m_fetch = 0; m_done = 0; m_err = 0; m_bytes = 0; m_wait = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_fetch) begin
      if (mem_ready) begin
        m_bytes++;
        m_wait = 0;
        if (m_bytes == 2) begin
          m_fetch = 0; m_done = 1;
        end
      end else begin
        m_wait++;
        if (TO_EN && m_wait == TO) begin
          m_fetch = 0; m_err = 1;
        end
      end
    end else if (start) begin
      m_fetch = 1; m_bytes = 0; m_wait = 0; m_err = 0;
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic m);
    rst = r; start = s; mem_ready = m;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0); tick();
    drive(1, 1, 1); tick();
    drive(0, 0, 0);
    checks++;
    if (act !== 16'h0000) begin
      errors++; $display("FAIL reset_idle got %h expected %h", act, 16'h0000);
    end
    tick();
  endtask

  task automatic test_basic(input logic [7:0] pc0, input string nm);
    int lo_c = -1, hi_c = -1, dn_c = -1;
    logic [7:0] exp_pc;
    set_pc(pc0);
    exp_pc = pc0 + 8'd2;
    for (int c = 0; c <= 4; c++) begin
      drive(0, c == 0, 1);
      checks++;
      if (act !== model_out()) begin
        errors++; $display("FAIL %s_outs cycle %0d got %h expected %h", nm, c, act, model_out());
      end
      if (ir_enable && !ir_lh && lo_c < 0) lo_c = c;
      if (ir_enable && ir_lh && hi_c < 0) hi_c = c;
      if (done && dn_c < 0) dn_c = c;
      tick();
    end
    checks++;
    if (lo_c !== 1 || hi_c !== 2 || dn_c !== 3) begin
      errors++; $display("FAIL %s_latency got lo=%0d hi=%0d done=%0d expected 1 2 3", nm, lo_c, hi_c, dn_c);
    end
    checks++;
    if (pc_now() !== exp_pc) begin
      errors++; $display("FAIL %s_pc got %h expected %h", nm, pc_now(), exp_pc);
    end
  endtask

  task automatic test_stall();
    int dn_c = -1;
    set_pc(8'h40);
    for (int c = 0; c <= 9; c++) begin
      drive(0, c == 0, (c == 4 || c == 7 || c >= 8));
      checks++;
      if (act !== model_out()) begin
        errors++; $display("FAIL stall_outs cycle %0d got %h expected %h", c, act, model_out());
      end
      if (done && dn_c < 0) dn_c = c;
      tick();
    end
    checks++;
    if (dn_c !== 8) begin
      errors++; $display("FAIL stall_done_cycle got %0d expected 8", dn_c);
    end
    checks++;
    if (pc_now() !== 8'h42) begin
      errors++; $display("FAIL stall_pc got %h expected 42", pc_now());
    end
  endtask

  task automatic test_back_to_back();
    int dn[$];
    set_pc(8'h20);
    for (int c = 0; c < 16; c++) begin
      drive(0, 1, 1);
      checks++;
      if (act !== model_out()) begin
        errors++; $display("FAIL b2b_outs cycle %0d got %h expected %h", c, act, model_out());
      end
      if (done) dn.push_back(c);
      tick();
    end
    checks++;
    if (dn.size() != 4 || dn[0] != 3 || dn[1] != 7 || dn[2] != 11 || dn[3] != 15) begin
      errors++; $display("FAIL b2b_done_cycles got %0d pulses expected 4 at 3,7,11,15", dn.size());
    end
    checks++;
    if (pc_now() !== 8'h28) begin
      errors++; $display("FAIL b2b_pc got %h expected 28", pc_now());
    end
    drive(0, 0, 0); tick(); tick();
  endtask

  task automatic test_reset_mid();
    int i0;
    bit seen_done = 0;
    i0 = incs;
    drive(0, 1, 1); tick();
    drive(0, 0, 1); tick();
    drive(1, 0, 0);
    checks++;
    if (act !== model_out()) begin
      errors++; $display("FAIL rstmid_hi got %h expected %h", act, model_out());
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 1);
      checks++;
      if (act !== 16'h0000) begin
        errors++; $display("FAIL rstmid_idle cycle %0d got %h expected 0000", c, act);
      end
      if (done) seen_done = 1;
      tick();
    end
    checks++;
    if (incs - i0 != 1 || seen_done) begin
      errors++; $display("FAIL rstmid_incs got %0d done=%0d expected 1 done=0", incs - i0, seen_done);
    end
  endtask

  task automatic test_timeout();
    for (int c = 0; c <= 100; c++) begin
      drive(0, c == 0, 0);
      checks++;
      if (act !== model_out()) begin
        errors++; $display("FAIL timeout_outs cycle %0d got %h expected %h", c, act, model_out());
      end
      tick();
    end
    checks++;
    if (err !== TO_EN || busy !== !TO_EN) begin
      errors++; $display("FAIL timeout_state got err=%b busy=%b expected err=%b busy=%b", err, busy, TO_EN, !TO_EN);
    end
    drive(0, 1, 0); tick();
    drive(0, 0, 0);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1 || act !== model_out()) begin
      errors++; $display("FAIL timeout_recover got %h expected %h", act, model_out());
    end
    drive(1, 0, 0); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 40) == 0, $urandom % 2, ($urandom % 4) != 0);
      checks++;
      if (act !== model_out()) begin
        errors++; $display("FAIL random_outs cycle %0d got %h expected %h", c, act, model_out());
      end
      tick();
    end
  endtask

  initial begin
    rst = 1; start = 0; mem_ready = 0;
    test_reset();
    test_basic(8'h10, "basic");
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_basic(8'hFF, "wrap");
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
